// File: rtl/button_debouncer.sv
// Push-button front end: a 2-flop synchronizer, a debounce FSM and a press-edge
// pulse for each raw button line. Each channel is an independent slice.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | debounced level low, synchronized input low
// WAIT_HI | input went high, counting consecutive high samples
// PRESSED | debounced level high, synchronized input high
// WAIT_LO | input went low, counting consecutive low samples
module button_debouncer #(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] i_buttons,
    output logic [N_BUTTONS-1:0] o_pulse,
    output logic [N_BUTTONS-1:0] o_level
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        PRESSED = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    logic [N_BUTTONS-1:0] sync1_q;
    logic [N_BUTTONS-1:0] sync2_q;

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_buttons;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        state_e               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 level_q, level_d;
        logic                 pulse_q, pulse_d;
        logic                 s;

        assign s = sync2_q[g];

        // Channel state, counter and registered outputs.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= CNT_ZERO;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        // Next-state logic; a bounce returns to the stable state and the count
        // restarts from 1 on the next re-entry, so it never accumulates.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = CNT_ZERO;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_d = PRESSED;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b0;
                end
            endcase
        end

        assign o_pulse[g] = pulse_q;
        assign o_level[g] = level_q;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with a short debounce time. A history-based
// reference model predicts level/pulse two edges ahead into a scoreboard queue;
// segment tables and reset sequences add hand-derived end-of-segment checks.
module tb_button_debouncer;

    localparam int NB = 3;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] i_buttons;
    logic [NB-1:0] o_pulse;
    logic [NB-1:0] o_level;

    button_debouncer #(.N_BUTTONS(NB), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_buttons (i_buttons),
        .o_pulse   (o_pulse),
        .o_level   (o_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] btn;
        int            hold;
        logic [NB-1:0] exp_level;
        int            exp_pulses;
    } seg_t;

    typedef struct {
        logic [NB-1:0] lvl;
        logic [NB-1:0] pls;
    } exp_t;

    exp_t          sbq[$];
    logic [NB-1:0] hist [DC];
    logic [NB-1:0] m_level;
    int            checks   = 0;
    int            failures = 0;
    int            seg_pulses;
    seg_t          tbl [16];

    task automatic check_vec(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Level flips to v once the last DC raw samples all equal v; a rising
    // flip also yields the pulse. Result becomes visible two edges later.
    task automatic model_push(input logic [NB-1:0] b);
        exp_t e;
        logic all_same;
        for (int i = DC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = b;
        e.pls = '0;
        for (int ch = 0; ch < NB; ch++) begin
            all_same = 1'b1;
            for (int i = 1; i < DC; i++) if (hist[i][ch] !== hist[0][ch]) all_same = 1'b0;
            if (all_same && (hist[0][ch] !== m_level[ch])) begin
                m_level[ch] = hist[0][ch];
                if (hist[0][ch]) e.pls[ch] = 1'b1;
            end
        end
        e.lvl = m_level;
        sbq.push_back(e);
    endtask

    task automatic cycle(input logic [NB-1:0] b);
        exp_t e;
        @(negedge clk);
        reset     = 1'b0;
        i_buttons = b;
        model_push(b);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check_int("scoreboard_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            check_vec("sb_level", o_level, e.lvl);
            check_vec("sb_pulse", o_pulse, e.pls);
        end
        seg_pulses += $countones(o_pulse);
    endtask

    task automatic do_reset(input logic [NB-1:0] b);
        exp_t z;
        @(negedge clk);
        reset     = 1'b1;
        i_buttons = b;
        @(posedge clk);
        #1;
        check_vec("reset_level", o_level, '0);
        check_vec("reset_pulse", o_pulse, '0);
        sbq.delete();
        for (int i = 0; i < DC; i++) hist[i] = '0;
        m_level = '0;
        z.lvl = '0;
        z.pls = '0;
        sbq.push_back(z);
        sbq.push_back(z);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_k;
        tbl[0]  = '{3'b000,    5, 3'b000, 0};
        tbl[1]  = '{3'b001,   20, 3'b001, 1};
        tbl[2]  = '{3'b000,    3, 3'b001, 0};
        tbl[3]  = '{3'b001,   10, 3'b001, 0};
        tbl[4]  = '{3'b000,   10, 3'b000, 0};
        tbl[5]  = '{3'b010,    1, 3'b000, 0};
        tbl[6]  = '{3'b000,    1, 3'b000, 0};
        tbl[7]  = '{3'b010,    1, 3'b000, 0};
        tbl[8]  = '{3'b010,    1, 3'b000, 0};
        tbl[9]  = '{3'b000,    1, 3'b000, 0};
        tbl[10] = '{3'b010,   10, 3'b010, 1};
        tbl[11] = '{3'b000,   10, 3'b000, 0};
        tbl[12] = '{3'b111,   10, 3'b111, 3};
        tbl[13] = '{3'b000,   10, 3'b000, 0};
        tbl[14] = '{3'b001, 1000, 3'b001, 1};
        tbl[15] = '{3'b000,   10, 3'b000, 0};

        reset     = 1'b1;
        i_buttons = '0;
        m_level   = '0;
        do_reset('0);

        for (int r = 0; r < 16; r++) begin
            seg_pulses = 0;
            for (int c = 0; c < tbl[r].hold; c++) cycle(tbl[r].btn);
            check_vec("seg_level", o_level, tbl[r].exp_level);
            check_int("seg_pulses", seg_pulses, tbl[r].exp_pulses);
        end

        // Reset in the middle of a debounce: the pending press is dropped and a
        // fresh full debounce starts; pulse lands 6 edges after the reset edge.
        for (int i = 0; i < 3; i++) cycle(3'b100);
        do_reset(3'b100);
        first_k    = 0;
        seg_pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle(3'b100);
            if (o_pulse[2] && first_k == 0) first_k = k;
        end
        check_int("rst_mid_pulse_edge", first_k, 6);
        check_int("rst_mid_pulse_count", seg_pulses, 1);
        check_vec("rst_mid_level", o_level, 3'b100);

        // Button already accepted and held through reset: counts as a new press.
        do_reset(3'b100);
        first_k    = 0;
        seg_pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle(3'b100);
            if (o_pulse[2] && first_k == 0) first_k = k;
        end
        check_int("rst_held_pulse_edge", first_k, 6);
        check_int("rst_held_pulse_count", seg_pulses, 1);

        for (int i = 0; i < 10; i++) cycle(3'b000);
        check_vec("final_level", o_level, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
